shift_unit_seq: RTL and testbench

- Parametrised, iterative, multi-mode shifter for the datapath ALU. Generalises the fixed 8-bit combinational left/right/arithmetic/rotate shifters.
- Accepts one operand, shift amount and opcode through a valid/ready handshake. Shifts one bit position per clock.
- Presents the result with carry-out and zero flags through a second valid/ready handshake.
- Sits between the register-file read ports and the ALU result mux. Used for shift/rotate instructions, trading latency for area.

---
 rtl/shift_unit_seq.sv | 106 ++++++++++
 tb/tb_shift_unit_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// Iterative multi-mode shifter (SLL/SRL/SRA/ROR/ROL), one bit position per clock,
// with valid/ready handshakes on the request and result sides.
module shift_unit_seq #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   INPUT,
    input  logic [SHAMT_W-1:0] SHIFT,
    input  logic [2:0]         OP,
    input  logic               FLUSH,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [WIDTH-1:0]   OUT,
    output logic               CARRY,
    output logic               ZERO,
    output logic               BUSY
);

    localparam logic [2:0] OpSll = 3'b000;
    localparam logic [2:0] OpSrl = 3'b001;
    localparam logic [2:0] OpSra = 3'b010;
    localparam logic [2:0] OpRor = 3'b011;
    localparam logic [2:0] OpRol = 3'b100;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [2:0]         op_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               carry_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            data_q  <= '0;
            op_q    <= OpSll;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else if (FLUSH) begin
            // Abort discards the result but leaves the data register untouched.
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (IN_VALID) begin
                        data_q  <= INPUT;
                        op_q    <= OP;
                        cnt_q   <= SHIFT;
                        carry_q <= 1'b0;
                        // Zero-length shifts and reserved opcodes pass the operand through.
                        state_q <= (SHIFT == '0 || OP > OpRol) ? StDone : StShift;
                    end
                end
                StShift: begin
                    unique case (op_q)
                        OpSll: begin
                            data_q  <= {data_q[WIDTH-2:0], 1'b0};
                            carry_q <= data_q[WIDTH-1];
                        end
                        OpSrl: begin
                            data_q  <= {1'b0, data_q[WIDTH-1:1]};
                            carry_q <= data_q[0];
                        end
                        OpSra: begin
                            data_q  <= {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                            carry_q <= data_q[0];
                        end
                        OpRor: begin
                            data_q  <= {data_q[0], data_q[WIDTH-1:1]};
                            carry_q <= data_q[0];
                        end
                        OpRol: begin
                            data_q  <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                            carry_q <= data_q[WIDTH-1];
                        end
                        default: ;
                    endcase
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (OUT_READY) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign IN_READY  = (state_q == StIdle);
    assign BUSY      = (state_q == StShift);
    assign OUT_VALID = (state_q == StDone);
    assign OUT       = data_q;
    assign CARRY     = carry_q;
    // Qualified by OUT_VALID so the flag reads 0 out of reset despite OUT == 0.
    assign ZERO      = OUT_VALID && (data_q == '0);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq (WIDTH=8).
module tb_shift_unit_seq;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] INPUT;
    logic [2:0] SHIFT;
    logic [2:0] OP;
    logic       FLUSH;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] OUT;
    logic       CARRY;
    logic       ZERO;
    logic       BUSY;

    int checks   = 0;
    int failures = 0;

    shift_unit_seq #(
        .WIDTH(8),
        .SHAMT_W(3)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .INPUT    (INPUT),
        .SHIFT    (SHIFT),
        .OP       (OP),
        .FLUSH    (FLUSH),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT      (OUT),
        .CARRY    (CARRY),
        .ZERO     (ZERO),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request; returns #1 after the accepting edge with inputs scrambled.
    task automatic start(input logic [2:0] op, input logic [7:0] din, input logic [2:0] sh);
        int k = 0;
        while (!IN_READY && k < 50) begin
            @(posedge CLK);
            #1;
            k++;
        end
        chk("ready_before_start", {31'b0, IN_READY}, 32'd1);
        IN_VALID = 1'b1;
        INPUT    = din;
        SHIFT    = sh;
        OP       = op;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        INPUT    = 8'hFF;
        SHIFT    = 3'd0;
        OP       = 3'b000;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int k    = 0;
        int busy = 0;
        while (!OUT_VALID && k < 40) begin
            if (BUSY) busy++;
            @(posedge CLK);
            #1;
            k++;
        end
        chk({tag, "_valid"}, {31'b0, OUT_VALID}, 32'd1);
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_busy_cycles"}, busy, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [7:0] o, input logic c,
                                input logic z);
        chk({tag, "_out"}, {24'b0, OUT}, {24'b0, o});
        chk({tag, "_carry"}, {31'b0, CARRY}, {31'b0, c});
        chk({tag, "_zero"}, {31'b0, ZERO}, {31'b0, z});
    endtask

    task automatic pop(input string tag);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk({tag, "_pop_in_ready"}, {31'b0, IN_READY}, 32'd1);
        chk({tag, "_pop_out_valid"}, {31'b0, OUT_VALID}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] din,
                       input logic [2:0] sh, input int lat, input logic [7:0] o,
                       input logic c, input logic z);
        start(op, din, sh);
        wait_done(tag, lat);
        check_result(tag, o, c, z);
        pop(tag);
    endtask

    initial begin
        RESET     = 1'b0;
        IN_VALID  = 1'b0;
        INPUT     = 8'h00;
        SHIFT     = 3'd0;
        OP        = 3'b000;
        FLUSH     = 1'b0;
        OUT_READY = 1'b0;
        #12;
        check_result("reset", 8'h00, 1'b0, 1'b0);
        chk("reset_out_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("reset_busy", {31'b0, BUSY}, 32'd0);
        chk("reset_in_ready", {31'b0, IN_READY}, 32'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        run("sll3", 3'b000, 8'h96, 3'd3, 3, 8'hB0, 1'b0, 1'b0);
        run("sra2", 3'b010, 8'h96, 3'd2, 2, 8'hE5, 1'b1, 1'b0);
        run("srl2", 3'b001, 8'h96, 3'd2, 2, 8'h25, 1'b1, 1'b0);
        run("ror1", 3'b011, 8'h81, 3'd1, 1, 8'hC0, 1'b1, 1'b0);
        run("rol7", 3'b100, 8'h81, 3'd7, 7, 8'hC0, 1'b0, 1'b0);
        run("srl0", 3'b001, 8'h5A, 3'd0, 0, 8'h5A, 1'b0, 1'b0);
        run("sll1", 3'b000, 8'h80, 3'd1, 1, 8'h00, 1'b1, 1'b1);
        // Carry is 1 from the previous op; a reserved op must clear it.
        run("rsv101", 3'b101, 8'h3C, 3'd5, 0, 8'h3C, 1'b0, 1'b0);
        run("rsv111", 3'b111, 8'h00, 3'd0, 0, 8'h00, 1'b0, 1'b1);

        // Backpressure, with a competing request that must be ignored.
        start(3'b000, 8'h96, 3'd3);
        wait_done("bp", 3);
        IN_VALID = 1'b1;
        INPUT    = 8'h11;
        SHIFT    = 3'd1;
        OP       = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            check_result("bp_hold", 8'hB0, 1'b0, 1'b0);
            chk("bp_out_valid", {31'b0, OUT_VALID}, 32'd1);
            chk("bp_in_ready", {31'b0, IN_READY}, 32'd0);
        end
        IN_VALID = 1'b0;
        pop("bp");
        chk("bp_no_queue_busy", {31'b0, BUSY}, 32'd0);

        // FLUSH asserted for edge 3: two shifts done, then back to idle.
        start(3'b000, 8'h96, 3'd7);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0;
        chk("flush_in_ready", {31'b0, IN_READY}, 32'd1);
        chk("flush_busy", {31'b0, BUSY}, 32'd0);
        chk("flush_data_kept", {24'b0, OUT}, 32'h58);
        for (int i = 0; i < 8; i++) begin
            chk("flush_no_valid", {31'b0, OUT_VALID}, 32'd0);
            @(posedge CLK);
            #1;
        end

        // Asynchronous reset mid-shift, observed between clock edges.
        start(3'b000, 8'h96, 3'd7);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        chk("rst_mid_busy_before", {31'b0, BUSY}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        check_result("rst_mid", 8'h00, 1'b0, 1'b0);
        chk("rst_mid_out_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("rst_mid_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_mid_in_ready", {31'b0, IN_READY}, 32'd1);
        #2;
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            chk("rst_mid_no_valid", {31'b0, OUT_VALID}, 32'd0);
        end

        run("post_rst_sra", 3'b010, 8'h41, 3'd1, 1, 8'h20, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
